// File: rtl/fp_add_sequencer.sv
// rtl/fp_add_sequencer.sv - multi-cycle single-precision adder sequencer with truncation
package fp;
   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } float;
endpackage

module fp_add_sequencer (
   input  logic    clock,
   input  logic    reset,
   input  logic    in_valid,
   output logic    in_ready,
   input  fp::float a,
   input  fp::float b,
   output logic    out_valid,
   input  logic    out_ready,
   output fp::float result,
   output logic    busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMP, S_ALIGN, S_ADD, S_NORM, S_DONE
   } state_t;

   state_t      state_q, state_d;
   fp::float    op_a_q, op_a_d;
   fp::float    op_b_q, op_b_d;
   logic [23:0] big_sig_q, big_sig_d;
   logic [23:0] small_sig_q, small_sig_d;
   logic [7:0]  diff_q, diff_d;
   logic [7:0]  exp_q, exp_d;
   logic [24:0] sum_q, sum_d;
   logic        sign_q, sign_d;
   logic        sub_q, sub_d;
   fp::float    result_q, result_d;

   // operand ordering for CMP: big holds the larger magnitude, ties keep a
   logic        a_is_big;
   fp::float    big_op, small_op;
   logic [7:0]  big_eff, small_eff, exp_inc;

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;

   // magnitude compare and effective exponents used by CMP
   always_comb begin
      a_is_big  = (op_a_q.exp > op_b_q.exp) ||
                  ((op_a_q.exp == op_b_q.exp) && (op_a_q.frac >= op_b_q.frac));
      big_op    = a_is_big ? op_a_q : op_b_q;
      small_op  = a_is_big ? op_b_q : op_a_q;
      big_eff   = (big_op.exp == 8'd0) ? 8'd1 : big_op.exp;
      small_eff = (small_op.exp == 8'd0) ? 8'd1 : small_op.exp;
      exp_inc   = exp_q + 8'd1;
   end

   // next-state and datapath updates, one FSM step per cycle
   always_comb begin
      state_d     = state_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      big_sig_d   = big_sig_q;
      small_sig_d = small_sig_q;
      diff_d      = diff_q;
      exp_d       = exp_q;
      sum_d       = sum_q;
      sign_d      = sign_q;
      sub_d       = sub_q;
      result_d    = result_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_a_d  = a;
               op_b_d  = b;
               state_d = S_CMP;
            end
         end
         S_CMP: begin
            if (op_a_q.exp == 8'hFF || op_b_q.exp == 8'hFF) begin
               result_d = 32'h7FC0_0000;
               state_d  = S_DONE;
            end else begin
               big_sig_d   = {big_op.exp != 8'd0, big_op.frac};
               small_sig_d = {small_op.exp != 8'd0, small_op.frac};
               exp_d       = big_eff;
               diff_d      = big_eff - small_eff;
               sign_d      = big_op.sign;
               sub_d       = big_op.sign ^ small_op.sign;
               state_d     = S_ALIGN;
            end
         end
         S_ALIGN: begin
            if (diff_q == 8'd0) begin
               state_d = S_ADD;
            end else if (diff_q >= 8'd25) begin
               small_sig_d = 24'd0;
               state_d     = S_ADD;
            end else begin
               small_sig_d = small_sig_q >> 1;
               diff_d      = diff_q - 8'd1;
            end
         end
         S_ADD: begin
            if (sub_q) sum_d = {1'b0, big_sig_q} - {1'b0, small_sig_q};
            else       sum_d = {1'b0, big_sig_q} + {1'b0, small_sig_q};
            state_d = S_NORM;
         end
         S_NORM: begin
            if (sum_q == 25'd0) begin
               result_d = 32'h0000_0000;
               state_d  = S_DONE;
            end else if (sum_q[24]) begin
               sum_d = sum_q >> 1;
               exp_d = exp_inc;
               if (exp_inc == 8'hFF) result_d = {sign_q, 8'hFF, 23'd0};
               else                  result_d = {sign_q, exp_inc, sum_q[23:1]};
               state_d = S_DONE;
            end else if (sum_q[23] || exp_q == 8'd1) begin
               result_d = {sign_q, (sum_q[23] ? exp_q : 8'd0), sum_q[22:0]};
               state_d  = S_DONE;
            end else begin
               sum_d = sum_q << 1;
               exp_d = exp_q - 8'd1;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers; reset discards any operation in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         big_sig_q   <= '0;
         small_sig_q <= '0;
         diff_q      <= '0;
         exp_q       <= '0;
         sum_q       <= '0;
         sign_q      <= 1'b0;
         sub_q       <= 1'b0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         big_sig_q   <= big_sig_d;
         small_sig_q <= small_sig_d;
         diff_q      <= diff_d;
         exp_q       <= exp_d;
         sum_q       <= sum_d;
         sign_q      <= sign_d;
         sub_q       <= sub_d;
         result_q    <= result_d;
      end
   end

endmodule
